prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-stream program loader; the write side of program memory, whose read side is the rom indexed by the program counter.
- Accepts a framed image over a valid/ready byte interface and assembles 14-bit opcodes.
- Writes each opcode into program memory at consecutive addresses.
- Holds the core (pcounter/inst_reg) in reset while a load is active and reports done or error at the end.

Parameters:
- ADDR_W, 11, program-memory address width (matches counter width)
- DATA_W, 14, opcode width
- MAX_WORDS, 2048, largest legal image length in words
- BASE_ADDR, 0, address of the first written word

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a new load session; sampled in IDLE/ERR only
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept; a byte transfers on a clk edge with rx_valid & rx_ready
- pm_we  out  1  program-memory write strobe
- pm_addr  out  ADDR_W  write address
- pm_wdata  out  DATA_W  opcode to write
- core_hold  out  1  keeps the core in reset while high
- done  out  1  one-cycle pulse on successful load
- error  out  1  sticky load failure
- words_loaded  out  12  count of words written this session

Behaviour:
- Reset values (reset low, asynchronous):
  - state IDLE
  - rx_ready=0, pm_we=0, pm_addr=BASE_ADDR, pm_wdata=0
  - core_hold=0, done=0, error=0, words_loaded=0
  - checksum accumulator=0
- Frame format:
  - LEN_HI byte: bits[3:0]=N[11:8]; bits[7:4] are ignored.
  - LEN_LO byte: N[7:0].
  - N word pairs (HI, LO): HI bits[5:0]=opcode[13:8], HI bits[7:6] must be 00; LO=opcode[7:0].
  - CSUM byte: sum mod 256 of the 2N word bytes. Length bytes are excluded from the sum.
- States: IDLE, LEN_HI, LEN_LO, W_HI, W_LO, CSUM, ERR.
- IDLE/ERR:
  - rx_ready=0; bytes are not consumed.
  - start=1 on an edge → LEN_HI, core_hold=1, error=0, words_loaded=0, pm_addr=BASE_ADDR, accumulator=0.
- Busy states (LEN_HI..CSUM):
  - rx_ready=1 every cycle; state advances only on accept.
  - start is ignored.
- LEN_LO accept:
  - If N==0 or N>MAX_WORDS → ERR.
  - Otherwise → W_HI.
- W_HI accept:
  - If bits[7:6]≠00 → ERR; no write for that word.
  - Otherwise latch the high 6 bits, add the byte to the accumulator, → W_LO.
- W_LO accept:
  - Add the byte to the accumulator.
  - In the following cycle: pm_we=1 for exactly one cycle, pm_wdata={hi6,byte}, pm_addr=BASE_ADDR+i.
  - pm_addr increments (mod 2^ADDR_W) and words_loaded increments at the end of that write cycle.
  - → W_HI if words remain, else → CSUM.
  - Back-to-back LO→HI accepts are legal; the write of word i overlaps reception of word i+1.
- CSUM accept:
  - Match: done=1 for the next cycle, core_hold=0 in that same cycle, → IDLE.
  - Mismatch: → ERR.
- ERR:
  - error=1 from the cycle after the offending accept.
  - core_hold stays 1; already-written words are not rolled back.
  - Exit only via start or reset.
- Flow control: rx_valid may drop at any point; gaps of any length are legal and do not alter results.
- Full-size image: at N=MAX_WORDS with BASE_ADDR=0, the last write is to address 2047 and pm_addr then wraps to 0.
- Reset mid-load: all outputs return to reset values immediately. The partial image stays in memory; a fresh start reloads from BASE_ADDR.
- Latency: one accepted byte per cycle maximum. Total cycles from start to done equals 2N+3 accepts, plus 1 cycle for the done pulse.

Test Plan:
1. start; bytes 00 02 01 23 3F FF 62 → pm_we twice: 0x0123@0, 0x3FFF@1; done pulses once; core_hold 1→0 in the done cycle; words_loaded=2; error=0.
2. Same frame with CSUM 63 → both writes occur; error=1; core_hold stays 1; rx_ready=0. A following start with a correct frame clears error and ends with done.
3. Length 00 00, and separately 08 01 (N=2049) → error=1 after LEN_LO accept; no pm_we; rx_ready drops.
4. N=1, HI byte 40 → error=1 on that accept; no pm_we. Then start with HI byte 3F → normal completion.
5. Frame from test 1 with rx_valid low for 3 cycles between every byte, plus bytes presented before start → identical writes and done; pre-start bytes are not consumed (rx_ready=0).
6. reset driven low after the first word's write in a 3-word load → all outputs reach reset values asynchronously. A new start with full frame → writes at 0,1,2, then done.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: receives a framed byte-stream image, assembles opcodes and
// writes them into program memory while holding the core in reset.
module prog_loader #(
   parameter int ADDR_W    = 11,
   parameter int DATA_W    = 14,
   parameter int MAX_WORDS = 2048,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              pm_we,
   output logic [ADDR_W-1:0] pm_addr,
   output logic [DATA_W-1:0] pm_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              error,
   output logic [11:0]       words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_W_HI, S_W_LO, S_CSUM, S_ERR
   } state_t;

   state_t      state, state_next;
   logic [3:0]  len_nib;
   logic [5:0]  hi6;
   logic [11:0] words_left;
   logic [7:0]  acc;
   logic [11:0] n_req;
   logic        len_bad;
   logic        load_go, lenhi_go, len_go, hi_go, lo_go, fail, finish;

   assign n_req   = {len_nib, rx_data};
   assign len_bad = (n_req == 12'd0) || ({1'b0, n_req} > 13'(MAX_WORDS));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      rx_ready   = 1'b0;
      load_go    = 1'b0;
      lenhi_go   = 1'b0;
      len_go     = 1'b0;
      hi_go      = 1'b0;
      lo_go      = 1'b0;
      fail       = 1'b0;
      finish     = 1'b0;
      unique case (state)
         S_IDLE, S_ERR: begin
            if (start) begin
               state_next = S_LEN_HI;
               load_go    = 1'b1;
            end
         end
         S_LEN_HI: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               state_next = S_LEN_LO;
               lenhi_go   = 1'b1;
            end
         end
         S_LEN_LO: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               if (len_bad) begin
                  state_next = S_ERR;
                  fail       = 1'b1;
               end else begin
                  state_next = S_W_HI;
                  len_go     = 1'b1;
               end
            end
         end
         S_W_HI: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               if (rx_data[7:6] != 2'b00) begin
                  state_next = S_ERR;
                  fail       = 1'b1;
               end else begin
                  state_next = S_W_LO;
                  hi_go      = 1'b1;
               end
            end
         end
         S_W_LO: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               lo_go      = 1'b1;
               state_next = (words_left == 12'd1) ? S_CSUM : S_W_HI;
            end
         end
         S_CSUM: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               if (acc == rx_data) begin
                  state_next = S_IDLE;
                  finish     = 1'b1;
               end else begin
                  state_next = S_ERR;
                  fail       = 1'b1;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // The write of a word lands one cycle after its LO byte, so the address
   // and count advance while the next word's HI byte may already be arriving.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pm_we        <= 1'b0;
         pm_addr      <= ADDR_W'(BASE_ADDR);
         pm_wdata     <= '0;
         core_hold    <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
         acc          <= '0;
         len_nib      <= '0;
         hi6          <= '0;
         words_left   <= '0;
      end else begin
         done  <= finish;
         pm_we <= lo_go;
         if (pm_we) begin
            pm_addr      <= pm_addr + 1'b1;
            words_loaded <= words_loaded + 1'b1;
         end
         if (lenhi_go) len_nib <= rx_data[3:0];
         if (len_go)   words_left <= n_req;
         if (hi_go) begin
            hi6 <= rx_data[5:0];
            acc <= acc + rx_data;
         end
         if (lo_go) begin
            pm_wdata   <= DATA_W'({hi6, rx_data});
            acc        <= acc + rx_data;
            words_left <= words_left - 1'b1;
         end
         if (fail)   error     <= 1'b1;
         if (finish) core_hold <= 1'b0;
         if (load_go) begin
            core_hold    <= 1'b1;
            error        <= 1'b0;
            words_loaded <= '0;
            pm_addr      <= ADDR_W'(BASE_ADDR);
            acc          <= '0;
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: normal load, checksum/length/header errors,
// flow-control gaps and asynchronous reset in the middle of a load.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        pm_we;
   logic [10:0] pm_addr;
   logic [13:0] pm_wdata;
   logic        core_hold;
   logic        done;
   logic        error;
   logic [11:0] words_loaded;

   int checks = 0;
   int fails  = 0;

   logic [10:0] wa [0:63];
   logic [13:0] wd [0:63];
   int          wr_n = 0;
   int          done_n = 0;
   logic        hold_at_done = 1'b1;
   logic [7:0]  frame [$];

   prog_loader dut (
      .clk(clk), .reset(reset), .start(start),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
      .core_hold(core_hold), .done(done), .error(error),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   // Log every program-memory write and done pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (pm_we && wr_n < 64) begin
         wa[wr_n] <= pm_addr;
         wd[wr_n] <= pm_wdata;
         wr_n     <= wr_n + 1;
      end
      if (done) begin
         done_n       <= done_n + 1;
         hold_at_done <= core_hold;
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      for (int i = 0; i < gap; i++) @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      n = 0;
      while (!rx_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!rx_ready) begin
         fails++;
         $display("[TB] FAIL byte_accept: rx_ready=%0b required 1 within 20 cycles", rx_ready);
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input int gap);
      foreach (frame[i]) send_byte(frame[i], gap);
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({rx_ready, pm_we, pm_addr, pm_wdata, core_hold, done, error, words_loaded} !== '0) begin
         fails++;
         $display("[TB] FAIL reset_values: rdy=%0b we=%0b addr=%0h wd=%0h hold=%0b done=%0b err=%0b wl=%0d required all 0",
                  rx_ready, pm_we, pm_addr, pm_wdata, core_hold, done, error, words_loaded);
      end
      idle(2);
      reset = 1'b1;
      idle(2);
   endtask

   task automatic test_normal_load();
      int wb, db;
      wb = wr_n; db = done_n;
      pulse_start();
      checks++;
      if (core_hold !== 1'b1) begin
         fails++;
         $display("[TB] FAIL t1_hold_busy: core_hold=%0b required 1", core_hold);
      end
      frame = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h3F, 8'hFF, 8'h62};
      send_frame(0);
      idle(3);
      checks++;
      if (wr_n - wb !== 2 || wa[wb] !== 11'd0 || wd[wb] !== 14'h0123
          || wa[wb+1] !== 11'd1 || wd[wb+1] !== 14'h3FFF) begin
         fails++;
         $display("[TB] FAIL t1_writes: n=%0d %0h@%0h %0h@%0h required 2 0123@0 3fff@1",
                  wr_n - wb, wd[wb], wa[wb], wd[wb+1], wa[wb+1]);
      end
      checks++;
      if (done_n - db !== 1 || hold_at_done !== 1'b0) begin
         fails++;
         $display("[TB] FAIL t1_done: pulses=%0d hold_at_done=%0b required 1 0", done_n - db, hold_at_done);
      end
      checks++;
      if (words_loaded !== 12'd2 || error !== 1'b0 || core_hold !== 1'b0) begin
         fails++;
         $display("[TB] FAIL t1_status: wl=%0d err=%0b hold=%0b required 2 0 0", words_loaded, error, core_hold);
      end
   endtask

   task automatic test_bad_checksum();
      int wb, db;
      wb = wr_n; db = done_n;
      pulse_start();
      frame = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h3F, 8'hFF, 8'h63};
      send_frame(0);
      idle(2);
      checks++;
      if (error !== 1'b1 || core_hold !== 1'b1 || rx_ready !== 1'b0 || wr_n - wb !== 2 || done_n != db) begin
         fails++;
         $display("[TB] FAIL t2_csum_err: err=%0b hold=%0b rdy=%0b writes=%0d dones=%0d required 1 1 0 2 0",
                  error, core_hold, rx_ready, wr_n - wb, done_n - db);
      end
      pulse_start();
      checks++;
      if (error !== 1'b0) begin
         fails++;
         $display("[TB] FAIL t2_err_clear: error=%0b required 0", error);
      end
      frame = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h3F, 8'hFF, 8'h62};
      send_frame(0);
      idle(2);
      checks++;
      if (done_n - db !== 1 || error !== 1'b0 || words_loaded !== 12'd2) begin
         fails++;
         $display("[TB] FAIL t2_recover: dones=%0d err=%0b wl=%0d required 1 0 2", done_n - db, error, words_loaded);
      end
   endtask

   task automatic test_bad_length();
      int wb;
      wb = wr_n;
      pulse_start();
      frame = '{8'h00, 8'h00};
      send_frame(0);
      idle(2);
      checks++;
      if (error !== 1'b1 || rx_ready !== 1'b0 || wr_n != wb) begin
         fails++;
         $display("[TB] FAIL t3_len_zero: err=%0b rdy=%0b writes=%0d required 1 0 0", error, rx_ready, wr_n - wb);
      end
      pulse_start();
      frame = '{8'h08, 8'h01};
      send_frame(0);
      idle(2);
      checks++;
      if (error !== 1'b1 || rx_ready !== 1'b0 || wr_n != wb) begin
         fails++;
         $display("[TB] FAIL t3_len_2049: err=%0b rdy=%0b writes=%0d required 1 0 0", error, rx_ready, wr_n - wb);
      end
      pulse_start();
      frame = '{8'hF0, 8'h01, 8'h00, 8'h05, 8'h05};
      send_frame(0);
      idle(2);
      checks++;
      if (error !== 1'b0 || words_loaded !== 12'd1 || wd[wr_n-1] !== 14'h0005) begin
         fails++;
         $display("[TB] FAIL t3_len_upper_ignored: err=%0b wl=%0d wd=%0h required 0 1 0005", error, words_loaded, wd[wr_n-1]);
      end
   endtask

   task automatic test_bad_header();
      int wb, db;
      wb = wr_n; db = done_n;
      pulse_start();
      frame = '{8'h00, 8'h01, 8'h40};
      send_frame(0);
      idle(2);
      checks++;
      if (error !== 1'b1 || wr_n != wb) begin
         fails++;
         $display("[TB] FAIL t4_hi_err: err=%0b writes=%0d required 1 0", error, wr_n - wb);
      end
      pulse_start();
      frame = '{8'h00, 8'h01, 8'h3F, 8'h00, 8'h3F};
      send_frame(0);
      idle(2);
      checks++;
      if (wr_n - wb !== 1 || wa[wb] !== 11'd0 || wd[wb] !== 14'h3F00 || done_n - db !== 1 || error !== 1'b0) begin
         fails++;
         $display("[TB] FAIL t4_recover: writes=%0d %0h@%0h dones=%0d err=%0b required 1 3f00@0 1 0",
                  wr_n - wb, wd[wb], wa[wb], done_n - db, error);
      end
   endtask

   task automatic test_gaps();
      int wb, db, seen_ready;
      wb = wr_n; db = done_n; seen_ready = 0;
      @(negedge clk);
      rx_data  = 8'hAA;
      rx_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rx_ready) seen_ready++;
      end
      rx_valid = 1'b0;
      checks++;
      if (seen_ready != 0) begin
         fails++;
         $display("[TB] FAIL t5_idle_not_ready: rx_ready high %0d cycles required 0", seen_ready);
      end
      pulse_start();
      frame = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h3F, 8'hFF, 8'h62};
      send_frame(3);
      idle(3);
      checks++;
      if (wr_n - wb !== 2 || wa[wb] !== 11'd0 || wd[wb] !== 14'h0123
          || wa[wb+1] !== 11'd1 || wd[wb+1] !== 14'h3FFF || done_n - db !== 1 || error !== 1'b0) begin
         fails++;
         $display("[TB] FAIL t5_gapped_load: n=%0d %0h@%0h %0h@%0h dones=%0d err=%0b required 2 0123@0 3fff@1 1 0",
                  wr_n - wb, wd[wb], wa[wb], wd[wb+1], wa[wb+1], done_n - db, error);
      end
   endtask

   task automatic test_reset_midload();
      int wb, db;
      pulse_start();
      frame = '{8'h00, 8'h03, 8'h01, 8'h11};
      send_frame(0);
      idle(1);
      checks++;
      if (words_loaded !== 12'd1 || pm_addr !== 11'd1) begin
         fails++;
         $display("[TB] FAIL t6_pre_reset: wl=%0d addr=%0h required 1 1", words_loaded, pm_addr);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({rx_ready, pm_we, pm_addr, pm_wdata, core_hold, done, error, words_loaded} !== '0) begin
         fails++;
         $display("[TB] FAIL t6_async_reset: rdy=%0b we=%0b addr=%0h wd=%0h hold=%0b done=%0b err=%0b wl=%0d required all 0",
                  rx_ready, pm_we, pm_addr, pm_wdata, core_hold, done, error, words_loaded);
      end
      idle(1);
      reset = 1'b1;
      idle(1);
      wb = wr_n; db = done_n;
      pulse_start();
      frame = '{8'h00, 8'h03, 8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33, 8'h6C};
      send_frame(0);
      idle(2);
      checks++;
      if (wr_n - wb !== 3 || wa[wb] !== 11'd0 || wd[wb] !== 14'h0111 || wa[wb+1] !== 11'd1
          || wd[wb+1] !== 14'h0222 || wa[wb+2] !== 11'd2 || wd[wb+2] !== 14'h0333) begin
         fails++;
         $display("[TB] FAIL t6_reload_writes: n=%0d %0h@%0h %0h@%0h %0h@%0h required 3 0111@0 0222@1 0333@2",
                  wr_n - wb, wd[wb], wa[wb], wd[wb+1], wa[wb+1], wd[wb+2], wa[wb+2]);
      end
      checks++;
      if (done_n - db !== 1 || words_loaded !== 12'd3 || core_hold !== 1'b0) begin
         fails++;
         $display("[TB] FAIL t6_reload_done: dones=%0d wl=%0d hold=%0b required 1 3 0", done_n - db, words_loaded, core_hold);
      end
   endtask

   initial begin
      test_reset();
      test_normal_load();
      test_bad_checksum();
      test_bad_length();
      test_bad_header();
      test_gaps();
      test_reset_midload();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
